uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Boot-time writer for the core's instruction memory. Receives a length-prefixed program image over a UART RX line (8N1, LSB first), assembles little-endian 32-bit words and writes them to consecutive instruction-memory word slots. It holds the pipeline in reset until the image is complete. It sits between the board RX pin and the instruction-memory write port, beside the fetch stage that later reads that memory.

## Interface
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- MAX_WORDS, 1024, instruction-memory capacity in 32-bit words.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rx  in  1  asynchronous serial line, idle high.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  32  byte address of the write, word-aligned: 0, 4, 8, …
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  high while loading; drives the core reset.
- load_done  out  1  image fully written; sticky until rst.
- frame_error  out  1  framing or length error; sticky until rst.

## Operation
- rx passes through a 2-flop synchronizer. All timing is counted from the synchronized signal rx_s.
- **Receiver FSM**
  - RX_IDLE: wait for rx_s falling edge (rx_s=0, previous rx_s=1), then go to RX_START.
  - RX_START: wait H = CLKS_PER_BIT/2 (integer division) cycles, then sample. Sample 0 → RX_DATA. Sample 1 is a glitch → RX_IDLE, no byte produced.
  - RX_DATA: sample 8 bits, one every CLKS_PER_BIT cycles, first received bit → bit 0.
  - RX_STOP: sample after a further CLKS_PER_BIT cycles. Sample 1 → byte_valid pulse. Sample 0 → framing error. Either way, back to RX_IDLE in the same cycle.
- **Loader FSM**
  - L_LEN: collect 4 bytes, little-endian, into word count N (first byte → N[7:0]).
    - N == 0 → L_DONE.
    - N > MAX_WORDS → L_ERR.
    - Otherwise → L_DATA.
  - L_DATA: collect 4 bytes per word, little-endian (first byte → wdata[7:0]). After the 4th byte, issue one write and advance imem_addr by 4 after the write. After the N-th write → L_DONE.
  - L_DONE: load_done=1, cpu_hold=0. All further rx traffic is ignored; the receiver may run, but its bytes are discarded.
  - L_ERR: frame_error=1, cpu_hold=1, no writes. Exit only via rst.
- A framing error in any loader state other than L_DONE → L_ERR. The offending byte is discarded.
- N is 32 bits wide. The comparison against MAX_WORDS is unsigned, so N = 0xFFFFFFFF → L_ERR.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, frame_error=0. Both FSMs reset to their idle/L_LEN states, and all byte and word counters clear.
- rst mid-operation discards any partial byte, partial word and partial length. Loading restarts at address 0.

## Timing
- t0 = the cycle rx_s is first seen low.
- Start sample at t0+H. Data bit i (i = 0..7) sampled at t0+H+(i+1)·CLKS_PER_BIT. Stop sample at t0+H+9·CLKS_PER_BIT.
- byte_valid is internal and is asserted the cycle after the stop sample.
- imem_we, imem_addr and imem_wdata are registered outputs. imem_we is high for exactly one cycle, the cycle after byte_valid of a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle.
- Completion after the last write: load_done rises and cpu_hold falls in the cycle after the N-th imem_we pulse.
- Completion when N == 0: load_done rises and cpu_hold falls in the cycle after byte_valid of the 4th length byte.
- frame_error rises in the cycle after the stop sample that read 0, or after byte_valid of the 4th length byte when N > MAX_WORDS.
- Back-to-back bytes (stop bit followed immediately by the next start bit) must be received without loss. The receiver is back in RX_IDLE before the earliest possible next falling edge.
- Sustained throughput is one word per 40 bit times. No backpressure exists; the memory write port must accept every strobe.

## Test plan
Run all scenarios with CLKS_PER_BIT=16 and MAX_WORDS=4.
1. Send N=2 (bytes 02 00 00 00), then 93 00 50 00, then 13 01 A0 00 → exactly two imem_we pulses: addr 0x0 data 0x00500093, then addr 0x4 data 0x00A00113. One cycle after the second pulse, load_done=1 and cpu_hold=0.
2. Send N=0 → no imem_we. One cycle after the 4th length byte, load_done=1 and cpu_hold=0. Extra bytes sent afterwards → no writes, outputs unchanged.
3. Send N=1, then a data byte whose stop bit is driven 0 → frame_error=1 at stop sample +1, no imem_we, cpu_hold stays 1. A following valid word → still no writes.
4. Pulse rx low for 4 cycles while idle (less than H=8) → no byte. A following valid stream for N=1, word 0xDEADBEEF → a single write, addr 0 data 0xDEADBEEF.
5. Send N=5 (exceeds MAX_WORDS) → frame_error=1 after the 4th length byte. No writes, cpu_hold=1, load_done=0.
6. Send N=1 and 2 data bytes, then pulse rst. Resend N=1 with word 0x12345678 → one write, addr 0x0 data 0x12345678. No write from the aborted image.

Source files
------------

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART and writes
// little-endian 32-bit words into instruction memory, holding the core until done.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        frame_error
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {LLen, LData, LDone, LErr} ld_state_e;

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err;

  ld_state_e       ld_state_q, ld_state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     n_q, n_d;
  logic [31:0]     words_q, words_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     full_word;

  // Receiver: all timing is counted from the synchronized line rx_s_q.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        cnt_d = '0;
        if (!rx_s_q && rx_prev_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d      = '0;
          bit_cnt_d  = 3'd0;
          rx_state_d = rx_s_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d      = '0;
          rx_state_d = RxIdle;
          if (rx_s_q) byte_valid_d = 1'b1;
          else        frame_err    = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Each new byte lands in the top lane so the first byte ends up in bits [7:0].
  assign full_word = {shift_q, asm_q[31:8]};

  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (we_q) begin
      addr_d  = addr_q + 32'd4;
      words_d = words_q + 32'd1;
    end
    case (ld_state_q)
      LLen: begin
        if (frame_err) begin
          ld_state_d = LErr;
        end else if (byte_valid_q) begin
          asm_d      = full_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            n_d = full_word;
            if (full_word == 32'd0)          ld_state_d = LDone;
            else if (full_word > MaxWords)   ld_state_d = LErr;
            else                             ld_state_d = LData;
          end
        end
      end
      LData: begin
        if (frame_err) begin
          ld_state_d = LErr;
        end else begin
          if (byte_valid_q) begin
            asm_d      = full_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              we_d    = 1'b1;
              wdata_d = full_word;
            end
          end
          if (we_q && (words_q + 32'd1 == n_q)) ld_state_d = LDone;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= LLen;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      n_q          <= 32'd0;
      words_q      <= 32'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      n_q          <= n_d;
      words_q      <= words_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_hold    = (ld_state_q != LDone);
  assign load_done   = (ld_state_q == LDone);
  assign frame_error = (ld_state_q == LErr);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: expected writes go into a scoreboard queue
// that a forked monitor drains on every imem_we strobe.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        frame_error;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  uart_program_loader #(
    .CLKS_PER_BIT(16),
    .MAX_WORDS   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives start and data bits; returns right as the stop bit begins.
  task automatic byte_head(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop_bit;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_head(b, 1'b1);
    tick(16);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic restart();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (imem_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_we", {31'd0, imem_we}, 32'd0);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e[63:32]);
            chk("wr_data", imem_wdata, e[31:0]);
          end
        end
      end
    join_none

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_ferr", {31'd0, frame_error}, 32'd0);

    // Two-word image; load_done follows the second strobe by one cycle.
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h00A0_0113});
    send_word(32'd2);
    send_word(32'h0050_0093);
    send_byte(8'h13);
    send_byte(8'h01);
    send_byte(8'hA0);
    byte_head(8'h00, 1'b1);
    tick(12);
    chk("s1_done_early", {31'd0, load_done}, 32'd0);
    tick(1);
    chk("s1_done", {31'd0, load_done}, 32'd1);
    chk("s1_hold", {31'd0, cpu_hold}, 32'd0);
    tick(3);
    chk("s1_pending", exp_q.size(), 32'd0);
    restart();

    // Empty image: done right after the length, later traffic ignored.
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    byte_head(8'h00, 1'b1);
    tick(11);
    chk("s2_done_early", {31'd0, load_done}, 32'd0);
    chk("s2_hold_early", {31'd0, cpu_hold}, 32'd1);
    tick(1);
    chk("s2_done", {31'd0, load_done}, 32'd1);
    chk("s2_hold", {31'd0, cpu_hold}, 32'd0);
    tick(4);
    send_word(32'h4433_2211);
    tick(20);
    chk("s2_done_after", {31'd0, load_done}, 32'd1);
    chk("s2_hold_after", {31'd0, cpu_hold}, 32'd0);
    chk("s2_ferr_after", {31'd0, frame_error}, 32'd0);
    chk("s2_pending", exp_q.size(), 32'd0);
    restart();

    // Broken stop bit in a data byte.
    send_word(32'd1);
    byte_head(8'h13, 1'b0);
    tick(10);
    chk("s3_ferr_early", {31'd0, frame_error}, 32'd0);
    tick(1);
    chk("s3_ferr", {31'd0, frame_error}, 32'd1);
    chk("s3_hold", {31'd0, cpu_hold}, 32'd1);
    tick(5);
    rx = 1'b1;
    tick(40);
    send_word(32'h0000_0013);
    tick(20);
    chk("s3_ferr_after", {31'd0, frame_error}, 32'd1);
    chk("s3_hold_after", {31'd0, cpu_hold}, 32'd1);
    chk("s3_done_after", {31'd0, load_done}, 32'd0);
    chk("s3_pending", exp_q.size(), 32'd0);
    restart();

    // Short glitch while idle must not produce a byte.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    tick(20);
    chk("s4_done", {31'd0, load_done}, 32'd1);
    chk("s4_ferr", {31'd0, frame_error}, 32'd0);
    chk("s4_pending", exp_q.size(), 32'd0);
    restart();

    // Length above capacity.
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h00);
    byte_head(8'h00, 1'b1);
    tick(11);
    chk("s5_ferr_early", {31'd0, frame_error}, 32'd0);
    tick(1);
    chk("s5_ferr", {31'd0, frame_error}, 32'd1);
    chk("s5_hold", {31'd0, cpu_hold}, 32'd1);
    chk("s5_done", {31'd0, load_done}, 32'd0);
    tick(24);
    chk("s5_pending", exp_q.size(), 32'd0);
    restart();

    // Reset in the middle of a word, then a clean reload.
    send_word(32'd1);
    send_byte(8'h78);
    send_byte(8'h56);
    restart();
    chk("s6_rst_addr", imem_addr, 32'd0);
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    send_word(32'd1);
    send_word(32'h1234_5678);
    tick(20);
    chk("s6_done", {31'd0, load_done}, 32'd1);
    chk("s6_addr_adv", imem_addr, 32'd4);
    chk("s6_pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
